// File: rtl/hs_npu_axil_csr_bridge.sv
// hs_npu_axil_csr_bridge
//   AXI4-Lite slave front-end for the NPU control/status register window.
//   Accepts AW and W into independent one-entry buffers, checks the word
//   index against the implemented window (SLVERR outside it), and drives a
//   simple single-cycle register port shared by the write and read paths.
//   Reads return reg_rdata sampled RD_LATENCY cycles after reg_re.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   csr_aw* / csr_w* / csr_b*        AXI4-Lite write address/data/response
//   csr_ar* / csr_r*                 AXI4-Lite read address/data
//   reg_addr                         register word index
//   reg_we, reg_wdata, reg_wstrb     one-cycle write strobe with data/enables
//   reg_re, reg_rdata                one-cycle read strobe, returned data
//
// Handshake rule (all AXI channels): a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge. A source holds
// valid and its payload stable until that edge; this block never waits on
// valid before raising ready, and holds bvalid/bresp and rvalid/rdata/rresp
// stable until bready/rready.
//
// Arbitration: a write strobe always wins the register port. A read in its
// issue state holds off for the cycle in which reg_we fires and issues on
// the following cycle, so it observes the newly written value.
//
// FSM state is visible on the internal signals wr_state and rd_state.
module hs_npu_axil_csr_bridge #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int WINDOW_WORDS = 64,
  parameter int RD_LATENCY   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          csr_awvalid,
  output logic                          csr_awready,
  input  logic [ADDR_WIDTH-1:0]         csr_awaddr,
  input  logic [2:0]                    csr_awprot,
  input  logic                          csr_wvalid,
  output logic                          csr_wready,
  input  logic [DATA_WIDTH-1:0]         csr_wdata,
  input  logic [DATA_WIDTH/8-1:0]       csr_wstrb,
  output logic                          csr_bvalid,
  input  logic                          csr_bready,
  output logic [1:0]                    csr_bresp,
  input  logic                          csr_arvalid,
  output logic                          csr_arready,
  input  logic [ADDR_WIDTH-1:0]         csr_araddr,
  input  logic [2:0]                    csr_arprot,
  output logic                          csr_rvalid,
  input  logic                          csr_rready,
  output logic [DATA_WIDTH-1:0]         csr_rdata,
  output logic [1:0]                    csr_rresp,
  output logic [$clog2(WINDOW_WORDS)-1:0] reg_addr,
  output logic                          reg_we,
  output logic [DATA_WIDTH-1:0]         reg_wdata,
  output logic [DATA_WIDTH/8-1:0]       reg_wstrb,
  output logic                          reg_re,
  input  logic [DATA_WIDTH-1:0]         reg_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(WINDOW_WORDS);
  localparam logic [ADDR_WIDTH-1:0] WIN_LIMIT = ADDR_WIDTH'(WINDOW_WORDS);
  localparam logic [1:0] LAT_LAST = (RD_LATENCY == 0) ? 2'd0 : 2'(RD_LATENCY - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  // Write-side buffers
  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  awready_q, wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  // Read-side state
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [1:0]            lat_cnt;

  logic                  aw_hs, w_hs, b_hs;
  logic                  aw_full_nxt, w_full_nxt;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic                  wr_issue, rd_issue;

  // Protection bits carry no meaning for this register window.
  logic unused_prot;
  assign unused_prot = ^{csr_awprot, csr_arprot};

  assign aw_hs = csr_awvalid && awready_q;
  assign w_hs  = csr_wvalid && wready_q;
  assign b_hs  = bvalid_q && csr_bready;

  // A buffer frees only on the write response handshake, which is what
  // limits the write path to one outstanding transaction.
  assign aw_full_nxt = b_hs ? 1'b0 : (aw_full || aw_hs);
  assign w_full_nxt  = b_hs ? 1'b0 : (w_full || w_hs);

  // Low address bits select a byte within the word and are dropped.
  assign wr_idx      = aw_addr_q >> OFFS;
  assign rd_idx      = ar_addr_q >> OFFS;
  assign wr_in_range = wr_idx < WIN_LIMIT;
  assign rd_in_range = rd_idx < WIN_LIMIT;

  assign wr_issue = (wr_state == W_ISSUE) && wr_in_range;
  assign rd_issue = (rd_state == R_ISSUE) && rd_in_range && !wr_issue;

  assign reg_we    = wr_issue;
  assign reg_re    = rd_issue;
  assign reg_addr  = wr_issue ? wr_idx[IDX_W-1:0] :
                     (rd_issue ? rd_idx[IDX_W-1:0] : '0);
  assign reg_wdata = wr_issue ? w_data_q : '0;
  assign reg_wstrb = wr_issue ? w_strb_q : '0;

  assign csr_awready = awready_q;
  assign csr_wready  = wready_q;
  assign csr_bvalid  = bvalid_q;
  assign csr_bresp   = bresp_q;
  assign csr_arready = arready_q;
  assign csr_rvalid  = rvalid_q;
  assign csr_rdata   = rdata_q;
  assign csr_rresp   = rresp_q;

  // AW / W one-entry buffers; ready is the registered complement of full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      aw_full   <= aw_full_nxt;
      w_full    <= w_full_nxt;
      awready_q <= !aw_full_nxt;
      wready_q  <= !w_full_nxt;
      if (aw_hs) aw_addr_q <= csr_awaddr;
      if (w_hs) begin
        w_data_q <= csr_wdata;
        w_strb_q <= csr_wstrb;
      end
    end
  end

  // Write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_full && w_full) wr_state <= W_ISSUE;
        end
        W_ISSUE: begin
          bvalid_q <= 1'b1;
          bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
          wr_state <= W_RESP;
        end
        W_RESP: begin
          if (csr_bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      ar_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      lat_cnt   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (arready_q && csr_arvalid) begin
            ar_addr_q <= csr_araddr;
            arready_q <= 1'b0;
            rd_state  <= R_ISSUE;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_ISSUE: begin
          if (!rd_in_range) begin
            rdata_q  <= '0;
            rresp_q  <= RESP_SLVERR;
            rvalid_q <= 1'b1;
            rd_state <= R_RESP;
          end else if (!wr_issue) begin
            // Strobe fires this cycle (rd_issue); with zero latency the
            // register file answers in the same cycle.
            if (RD_LATENCY == 0) begin
              rdata_q  <= reg_rdata;
              rresp_q  <= RESP_OKAY;
              rvalid_q <= 1'b1;
              rd_state <= R_RESP;
            end else begin
              lat_cnt  <= '0;
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rdata_q  <= reg_rdata;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b1;
            rd_state <= R_RESP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        R_RESP: begin
          if (csr_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_npu_axil_csr_bridge.sv
module tb_hs_npu_axil_csr_bridge;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (32-bit, RD_LATENCY=1) ----------------
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata, reg_wdata, reg_rdata;
  logic [3:0]  wstrb, reg_wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [5:0]  reg_addr;
  logic        reg_we, reg_re;

  hs_npu_axil_csr_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WINDOW_WORDS(64), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .csr_awvalid(awvalid), .csr_awready(awready), .csr_awaddr(awaddr), .csr_awprot(awprot),
    .csr_wvalid(wvalid), .csr_wready(wready), .csr_wdata(wdata), .csr_wstrb(wstrb),
    .csr_bvalid(bvalid), .csr_bready(bready), .csr_bresp(bresp),
    .csr_arvalid(arvalid), .csr_arready(arready), .csr_araddr(araddr), .csr_arprot(arprot),
    .csr_rvalid(rvalid), .csr_rready(rready), .csr_rdata(rdata), .csr_rresp(rresp),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_re(reg_re), .reg_rdata(reg_rdata)
  );

  // Register file behind the main DUT: byte-enabled writes, 1-cycle read.
  logic [31:0] mem [64];
  logic [31:0] rd_q;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rd_q = '0;
  end
  always @(posedge clk) begin
    if (reg_we)
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b]) mem[reg_addr][b*8 +: 8] <= reg_wdata[b*8 +: 8];
    if (reg_re) rd_q <= mem[reg_addr];
  end
  assign reg_rdata = rd_q;

  // Strobe monitors
  int we_cnt = 0, re_cnt = 0, both_cnt = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (reg_we) we_cnt <= we_cnt + 1;
      if (reg_re) re_cnt <= re_cnt + 1;
      if (reg_we && reg_re) both_cnt <= both_cnt + 1;
    end
  end

  // Back-pressure stability monitor
  logic bp_mon = 1'b0;
  int   bp_bad = 0;
  always @(posedge clk)
    if (bp_mon && (!bvalid || bresp != 2'b00 || awready)) bp_bad <= bp_bad + 1;

  // ---------------- sweep DUTs (64-bit, RD_LATENCY 0 and 3), shared inputs ----------------
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [15:0] s_awaddr, s_araddr;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  localparam logic [63:0] PAT = 64'hA5A5_0000_1234_5600;
  localparam logic [63:0] BAD = 64'hDEAD_DEAD_DEAD_DEAD;

  logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_we, a_re;
  logic [1:0]  a_bresp, a_rresp;
  logic [63:0] a_rdata, a_wd, a_rd_in;
  logic [7:0]  a_ws;
  logic [5:0]  a_addr;

  logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_we, b_re;
  logic [1:0]  b_bresp, b_rresp;
  logic [63:0] b_rdata, b_wd, b_rd_in;
  logic [7:0]  b_ws;
  logic [5:0]  b_addr;

  hs_npu_axil_csr_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .WINDOW_WORDS(64), .RD_LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .csr_awvalid(s_awvalid), .csr_awready(a_awready), .csr_awaddr(s_awaddr), .csr_awprot(3'b000),
    .csr_wvalid(s_wvalid), .csr_wready(a_wready), .csr_wdata(s_wdata), .csr_wstrb(s_wstrb),
    .csr_bvalid(a_bvalid), .csr_bready(s_bready), .csr_bresp(a_bresp),
    .csr_arvalid(s_arvalid), .csr_arready(a_arready), .csr_araddr(s_araddr), .csr_arprot(3'b000),
    .csr_rvalid(a_rvalid), .csr_rready(s_rready), .csr_rdata(a_rdata), .csr_rresp(a_rresp),
    .reg_addr(a_addr), .reg_we(a_we), .reg_wdata(a_wd), .reg_wstrb(a_ws),
    .reg_re(a_re), .reg_rdata(a_rd_in)
  );
  // Zero latency: data is only correct during the strobe cycle itself.
  assign a_rd_in = a_re ? (PAT | 64'(a_addr)) : BAD;

  hs_npu_axil_csr_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .WINDOW_WORDS(64), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .csr_awvalid(s_awvalid), .csr_awready(b_awready), .csr_awaddr(s_awaddr), .csr_awprot(3'b000),
    .csr_wvalid(s_wvalid), .csr_wready(b_wready), .csr_wdata(s_wdata), .csr_wstrb(s_wstrb),
    .csr_bvalid(b_bvalid), .csr_bready(s_bready), .csr_bresp(b_bresp),
    .csr_arvalid(s_arvalid), .csr_arready(b_arready), .csr_araddr(s_araddr), .csr_arprot(3'b000),
    .csr_rvalid(b_rvalid), .csr_rready(s_rready), .csr_rdata(b_rdata), .csr_rresp(b_rresp),
    .reg_addr(b_addr), .reg_we(b_we), .reg_wdata(b_wd), .reg_wstrb(b_ws),
    .reg_re(b_re), .reg_rdata(b_rd_in)
  );
  // Three-cycle latency: data is correct only exactly 3 cycles after the strobe.
  logic [2:0] b_re_d = '0;
  logic [5:0] b_addr_l = '0;
  always @(posedge clk) begin
    b_re_d <= {b_re_d[1:0], b_re};
    if (b_re) b_addr_l <= b_addr;
  end
  assign b_rd_in = b_re_d[2] ? (PAT | 64'(b_addr_l)) : BAD;

  // ---------------- scoreboard / checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(input int max_cycles);
    for (int k = 0; k < max_cycles && !rvalid; k++) tick();
    check_eq("rvalid_within_bound", rvalid, 1'b1);
  endtask

  task automatic start_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
  endtask

  task automatic release_b();
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic release_r();
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int we0, re0, a_lat, b_lat;
    rst_n = 1'b0;
    awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; arprot = 0; rready = 0;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
    s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0;
    repeat (3) tick();

    // Reset state
    check_eq("reset_ready", {awready, wready, arready}, 3'b000);
    check_eq("reset_valid", {bvalid, rvalid, reg_we, reg_re}, 4'b0000);
    check_eq("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    check_eq("ready_before_edge", {awready, wready, arready}, 3'b000);
    tick();
    check_eq("ready_after_edge", {awready, wready, arready}, 3'b111);

    // Aligned write then read
    start_write(16'h0010, 32'hDEADBEEF, 4'hF);
    tick();
    awvalid = 0; wvalid = 0;
    check_eq("w1_no_we_c1", reg_we, 1'b0);
    check_eq("w1_ready_low", {awready, wready}, 2'b00);
    tick();
    check_eq("w1_we_c2", reg_we, 1'b1);
    check_eq("w1_addr", reg_addr, 6'd4);
    check_eq("w1_wdata", reg_wdata, 32'hDEADBEEF);
    check_eq("w1_wstrb", reg_wstrb, 4'hF);
    tick();
    check_eq("w1_bvalid_c3", bvalid, 1'b1);
    check_eq("w1_bresp", bresp, 2'b00);
    release_b();
    check_eq("w1_bvalid_clr", bvalid, 1'b0);
    tick();
    check_eq("w1_awready_back", awready, 1'b1);

    arvalid = 1'b1; araddr = 16'h0010;
    tick();
    arvalid = 1'b0;
    check_eq("r1_re_c1", reg_re, 1'b1);
    check_eq("r1_addr", reg_addr, 6'd4);
    tick();
    check_eq("r1_no_rvalid_c2", rvalid, 1'b0);
    tick();
    check_eq("r1_rvalid_c3", rvalid, 1'b1);
    check_eq("r1_rdata", rdata, 32'hDEADBEEF);
    check_eq("r1_rresp", rresp, 2'b00);
    release_r();
    check_eq("r1_rvalid_clr", rvalid, 1'b0);

    // W first, AW five cycles later; a second W is held valid meanwhile
    we0 = we_cnt;
    wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF;
    tick();
    wdata = 32'h99999999;
    check_eq("w2_wready_low", wready, 1'b0);
    repeat (4) tick();
    check_eq("w2_no_we_before_aw", we_cnt, we0);
    awvalid = 1'b1; awaddr = 16'h0004;
    tick();
    awvalid = 1'b0;
    tick();
    check_eq("w2_we", reg_we, 1'b1);
    check_eq("w2_addr", reg_addr, 6'd1);
    check_eq("w2_wdata", reg_wdata, 32'h11223344);
    tick();
    check_eq("w2_bvalid", bvalid, 1'b1);
    check_eq("w2_second_w_blocked", wready, 1'b0);
    wvalid = 1'b0;
    release_b();
    tick();
    check_eq("w2_single_we", we_cnt, we0 + 1);

    // Out-of-range write and read
    we0 = we_cnt;
    start_write(16'h0100, 32'h12345678, 4'hF);
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    check_eq("oor_w_no_we", reg_we, 1'b0);
    tick();
    check_eq("oor_w_bvalid", bvalid, 1'b1);
    check_eq("oor_w_bresp", bresp, 2'b10);
    release_b();
    tick();
    check_eq("oor_w_we_count", we_cnt, we0);

    re0 = re_cnt;
    arvalid = 1'b1; araddr = 16'h0100;
    tick();
    arvalid = 1'b0;
    check_eq("oor_r_no_re", reg_re, 1'b0);
    tick();
    check_eq("oor_r_rvalid", rvalid, 1'b1);
    check_eq("oor_r_rdata", rdata, 32'h0);
    check_eq("oor_r_rresp", rresp, 2'b10);
    release_r();
    check_eq("oor_r_re_count", re_cnt, re0);

    // Collision on index 2: write ISSUE and read ISSUE meet in the same cycle
    start_write(16'h0008, 32'hCAFEF00D, 4'hF);
    tick();
    awvalid = 0; wvalid = 0;
    arvalid = 1'b1; araddr = 16'h0008;
    tick();
    arvalid = 1'b0;
    check_eq("col_we_n", reg_we, 1'b1);
    check_eq("col_re_held", reg_re, 1'b0);
    check_eq("col_addr_n", reg_addr, 6'd2);
    tick();
    check_eq("col_re_n1", reg_re, 1'b1);
    check_eq("col_addr_n1", reg_addr, 6'd2);
    check_eq("col_bvalid", bvalid, 1'b1);
    release_b();
    check_eq("col_no_rvalid_yet", rvalid, 1'b0);
    tick();
    check_eq("col_rvalid", rvalid, 1'b1);
    check_eq("col_rdata", rdata, 32'hCAFEF00D);
    release_r();

    // Write response back-pressure while a read completes
    start_write(16'h000C, 32'h5A5A0000, 4'h3);
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    tick();
    check_eq("bp_bvalid", bvalid, 1'b1);
    bp_mon = 1'b1;
    arvalid = 1'b1; araddr = 16'h0010;
    tick();
    arvalid = 1'b0;
    wait_rvalid(8);
    check_eq("bp_read_rdata", rdata, 32'hDEADBEEF);
    release_r();
    repeat (6) tick();
    bp_mon = 1'b0;
    check_eq("bp_stable_cycles_bad", bp_bad, 0);
    check_eq("bp_bresp_held", {bvalid, bresp}, 3'b100);
    release_b();

    // Reset asserted while the read sits in WAIT
    arvalid = 1'b1; araddr = 16'h0010;
    tick();
    arvalid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ready", {awready, wready, arready}, 3'b000);
    check_eq("rst_mid_valid", {bvalid, rvalid, reg_we, reg_re}, 4'b0000);
    check_eq("rst_mid_rdata", rdata, 32'h0);
    re0 = re_cnt;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("rst_no_stale_rvalid", rvalid, 1'b0);
    check_eq("rst_no_stale_re", re_cnt, re0);
    check_eq("rst_arready_back", arready, 1'b1);

    // 64-bit sweep: unaligned 0x2D -> index 5, 8-bit strobes
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 16'h002D;
    s_wdata = 64'h0011_2233_4455_6677; s_wstrb = 8'hA5;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    check_eq("sw_l0_we", a_we, 1'b1);
    check_eq("sw_l0_addr", a_addr, 6'd5);
    check_eq("sw_l0_wstrb", a_ws, 8'hA5);
    check_eq("sw_l0_wdata", a_wd, 64'h0011_2233_4455_6677);
    check_eq("sw_l3_we_addr", {b_we, b_addr}, {1'b1, 6'd5});
    tick();
    check_eq("sw_bvalid_both", {a_bvalid, b_bvalid}, 2'b11);
    s_bready = 1'b1; tick(); s_bready = 1'b0;

    s_arvalid = 1'b1; s_araddr = 16'h0030;
    tick();
    s_arvalid = 1'b0;
    check_eq("sw_re_both", {a_re, b_re}, 2'b11);
    check_eq("sw_re_addr", a_addr, 6'd6);
    a_lat = 0; b_lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (a_rvalid && a_lat == 0) a_lat = k;
      if (b_rvalid && b_lat == 0) b_lat = k;
      tick();
    end
    check_eq("sw_l0_rvalid_latency", a_lat, 2);
    check_eq("sw_l3_rvalid_latency", b_lat, 5);
    check_eq("sw_l0_rdata", a_rdata, 64'hA5A5_0000_1234_5606);
    check_eq("sw_l3_rdata", b_rdata, 64'hA5A5_0000_1234_5606);
    check_eq("sw_rresp", {a_rresp, b_rresp}, 4'b0000);
    s_rready = 1'b1; tick(); s_rready = 1'b0;

    check_eq("never_we_and_re", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
